// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - burst-granular round-robin arbiter sharing one memory port between I and D caches
// Read returns are routed back to their issuer through a tag pipe that keeps shifting while ownership changes.
module mem_port_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_rd,
   input  logic              i_wr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              i_grant,
   output logic              i_stall,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_grant,
   output logic              d_stall,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_stall,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_OWN_I = 2'd1;
   localparam logic [1:0] S_OWN_D = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              last_owner_q, last_owner_d;   // 0 = I, 1 = D
   logic [RD_LAT-1:0] tag_vld_q;
   logic [RD_LAT-1:0] tag_own_q;
   logic              tag_push;
   logic              pipe_busy;

   assign tag_push  = mem_rd && !mem_stall;
   assign pipe_busy = |tag_vld_q;

   assign i_grant = (state_q == S_OWN_I);
   assign d_grant = (state_q == S_OWN_D);

   assign i_rvalid = tag_vld_q[RD_LAT-1] && !tag_own_q[RD_LAT-1];
   assign d_rvalid = tag_vld_q[RD_LAT-1] &&  tag_own_q[RD_LAT-1];
   assign i_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      i_stall      = i_req;
      d_stall      = d_req;
      case (state_q)
         S_IDLE: begin
            if (i_req && d_req) begin
               state_d = last_owner_q ? S_OWN_I : S_OWN_D;
            end else if (i_req) begin
               state_d = S_OWN_I;
            end else if (d_req) begin
               state_d = S_OWN_D;
            end
         end
         S_OWN_I: begin
            i_stall = mem_stall;
            if (i_req) begin
               mem_wr    = i_wr;
               mem_rd    = i_rd && !i_wr;
               mem_addr  = i_addr;
               mem_wdata = i_wdata;
            end else begin
               last_owner_d = 1'b0;
               state_d      = pipe_busy ? S_DRAIN : S_IDLE;
            end
         end
         S_OWN_D: begin
            d_stall = mem_stall;
            if (d_req) begin
               mem_wr    = d_wr;
               mem_rd    = d_rd && !d_wr;
               mem_addr  = d_addr;
               mem_wdata = d_wdata;
            end else begin
               last_owner_d = 1'b1;
               state_d      = pipe_busy ? S_DRAIN : S_IDLE;
            end
         end
         default: begin
            if (!pipe_busy) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_owner_q <= 1'b0;
         tag_vld_q    <= '0;
         tag_own_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         for (int k = RD_LAT - 1; k > 0; k--) begin
            tag_vld_q[k] <= tag_vld_q[k-1];
            tag_own_q[k] <= tag_own_q[k-1];
         end
         tag_vld_q[0] <= tag_push;
         tag_own_q[0] <= (state_q == S_OWN_D);
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_rd, i_wr;
   logic [15:0] i_addr, i_wdata;
   logic        i_grant, i_stall, i_rvalid;
   logic [15:0] i_rdata;
   logic        d_req, d_rd, d_wr;
   logic [15:0] d_addr, d_wdata;
   logic        d_grant, d_stall, d_rvalid;
   logic [15:0] d_rdata;
   logic        mem_rd, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_stall;
   logic [15:0] mem_rdata;

   int vectors = 0;
   int miscompares = 0;
   int rv_count;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_grant(i_grant), .i_stall(i_stall), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_grant(d_grant), .d_stall(d_stall), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_stall(mem_stall), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200us");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      i_req = 0; i_rd = 0; i_wr = 0; i_addr = '0; i_wdata = '0;
      d_req = 0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
      mem_stall = 0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      cyc();
      clear_inputs();
      rst = 1;
      cyc();
      rst = 0;
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      cyc();
      cyc();
      smp();
      chk("rst_grants", 32'({i_grant, d_grant}), 32'h0);
      chk("rst_strobes", 32'({mem_rd, mem_wr}), 32'h0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_wdata", 32'(mem_wdata), 32'h0);
      chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);

      // D-only burst: 4 writes then 4 reads
      cyc();
      rst = 0;
      d_req = 1; d_wr = 1; d_addr = 16'h1A00; d_wdata = 16'h5A00;
      smp();
      chk("s1_idle_grant", 32'(d_grant), 32'h0);
      chk("s1_idle_stall", 32'(d_stall), 32'h1);
      chk("s1_idle_nowr", 32'(mem_wr), 32'h0);
      for (int c = 0; c < 11; c++) begin
         cyc();
         mem_rdata = 16'hD000 | 16'(c);
         if (c < 4) begin
            d_req = 1; d_wr = 1; d_rd = 0;
            d_addr = 16'h1A00 + 16'(2 * c); d_wdata = 16'h5A00 | 16'(c);
         end else if (c < 8) begin
            d_wr = 0; d_rd = 1;
            d_addr = 16'h1A00 + 16'(2 * (c - 4));
         end else begin
            d_req = 0; d_rd = 0; d_wr = 0;
         end
         smp();
         if (c < 4) begin
            chk("s1_wr_strobe", 32'({mem_rd, mem_wr}), 32'h1);
            chk("s1_wr_addr", 32'(mem_addr), 32'(16'h1A00 + 16'(2 * c)));
            chk("s1_wr_data", 32'(mem_wdata), 32'(16'h5A00 | 16'(c)));
         end else if (c < 8) begin
            chk("s1_rd_strobe", 32'({mem_rd, mem_wr}), 32'h2);
            chk("s1_rd_addr", 32'(mem_addr), 32'(16'h1A00 + 16'(2 * (c - 4))));
         end else begin
            chk("s1_no_strobe", 32'({mem_rd, mem_wr}), 32'h0);
         end
         chk("s1_dgrant", 32'(d_grant), 32'(c <= 8));
         chk("s1_drvalid", 32'(d_rvalid), 32'(c >= 6 && c <= 9));
         if (c >= 6 && c <= 9) chk("s1_drdata", 32'(d_rdata), 32'(16'hD000 | 16'(c)));
         chk("s1_i_quiet", 32'({i_grant, i_rvalid}), 32'h0);
      end

      // contention, drain, round-robin
      do_reset();
      i_req = 1; i_rd = 1; i_addr = 16'h0100;
      d_req = 1; d_rd = 1; d_addr = 16'h0200;
      smp();
      chk("s2_b0_stalls", 32'({i_stall, d_stall}), 32'h3);
      chk("s2_b0_grants", 32'({i_grant, d_grant}), 32'h0);
      cyc(); mem_rdata = 16'hB001;
      smp();
      chk("s2_b1_grants", 32'({i_grant, d_grant}), 32'h1);
      chk("s2_b1_istall", 32'(i_stall), 32'h1);
      chk("s2_b1_addr", 32'(mem_addr), 32'h0200);
      chk("s2_b1_rd", 32'(mem_rd), 32'h1);
      cyc(); d_addr = 16'h0202; mem_rdata = 16'hB002;
      smp();
      chk("s2_b2_addr", 32'(mem_addr), 32'h0202);
      cyc(); d_req = 0; d_rd = 0; mem_rdata = 16'hB003;
      smp();
      chk("s2_b3_rv", 32'({i_rvalid, d_rvalid}), 32'h1);
      chk("s2_b3_rdata", 32'(d_rdata), 32'hB003);
      chk("s2_b3_nord", 32'(mem_rd), 32'h0);
      chk("s2_b3_igrant", 32'(i_grant), 32'h0);
      cyc(); mem_rdata = 16'hB004;
      smp();
      chk("s2_b4_rv", 32'({i_rvalid, d_rvalid}), 32'h1);
      chk("s2_b4_rdata", 32'(d_rdata), 32'hB004);
      chk("s2_b4_grants", 32'({i_grant, d_grant}), 32'h0);
      chk("s2_b4_istall", 32'(i_stall), 32'h1);
      cyc(); mem_rdata = 16'hB005;
      smp();
      chk("s2_b5_rv", 32'({i_rvalid, d_rvalid}), 32'h0);
      chk("s2_b5_grants", 32'({i_grant, d_grant}), 32'h0);
      cyc();
      smp();
      chk("s2_b6_grants", 32'({i_grant, d_grant}), 32'h0);
      cyc(); mem_rdata = 16'hA007;
      smp();
      chk("s2_b7_grants", 32'({i_grant, d_grant}), 32'h2);
      chk("s2_b7_addr", 32'(mem_addr), 32'h0100);
      chk("s2_b7_rd", 32'(mem_rd), 32'h1);
      cyc(); i_addr = 16'h0102; d_req = 1;
      smp();
      chk("s2_b8_dstall", 32'(d_stall), 32'h1);
      chk("s2_b8_addr", 32'(mem_addr), 32'h0102);
      cyc(); i_req = 0; i_rd = 0; mem_rdata = 16'hA009;
      smp();
      chk("s2_b9_rv", 32'({i_rvalid, d_rvalid}), 32'h2);
      chk("s2_b9_rdata", 32'(i_rdata), 32'hA009);
      chk("s2_b9_dgrant", 32'(d_grant), 32'h0);
      cyc(); mem_rdata = 16'hA00A;
      smp();
      chk("s2_b10_rv", 32'({i_rvalid, d_rvalid}), 32'h2);
      chk("s2_b10_dgrant", 32'(d_grant), 32'h0);
      cyc(); i_req = 1;
      smp();
      chk("s2_b11_rv", 32'({i_rvalid, d_rvalid}), 32'h0);
      chk("s2_b11_grants", 32'({i_grant, d_grant}), 32'h0);
      cyc();
      smp();
      chk("s2_b12_grants", 32'({i_grant, d_grant}), 32'h0);
      cyc();
      smp();
      chk("s2_b13_rr_d", 32'({i_grant, d_grant}), 32'h1);
      cyc(); d_req = 0;
      smp();
      cyc(); d_req = 1;
      smp();
      chk("s2_b15_grants", 32'({i_grant, d_grant}), 32'h0);
      cyc();
      smp();
      chk("s2_b16_rr_i", 32'({i_grant, d_grant}), 32'h2);

      // memory stall mid read burst
      do_reset();
      d_req = 1; d_rd = 1; d_addr = 16'h1A00;
      rv_count = 0;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         mem_stall = (c >= 2 && c <= 4);
         if (c == 1) d_addr = 16'h1A00;
         else if (c <= 5) d_addr = 16'h1A02;
         else if (c == 6) d_addr = 16'h1A04;
         else if (c == 7) d_addr = 16'h1A06;
         else begin d_req = 0; d_rd = 0; end
         smp();
         if (d_rvalid) rv_count++;
         if (c >= 2 && c <= 4) begin
            chk("s3_stall", 32'(d_stall), 32'h1);
            chk("s3_addr_held", 32'(mem_addr), 32'h1A02);
         end
         if (c == 5) chk("s3_unstall", 32'(d_stall), 32'h0);
      end
      chk("s3_rvalid_count", 32'(rv_count), 32'd4);

      // reset mid-burst with reads in flight
      do_reset();
      d_req = 1; d_rd = 1; d_addr = 16'h1A10;
      cyc();
      cyc(); d_addr = 16'h1A12;
      cyc(); rst = 1;
      cyc(); rst = 0; d_req = 0; d_rd = 0; i_req = 1;
      smp();
      chk("s4_grants", 32'({i_grant, d_grant}), 32'h0);
      chk("s4_strobes", 32'({mem_rd, mem_wr}), 32'h0);
      chk("s4_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
      cyc();
      smp();
      chk("s4_igrant", 32'({i_grant, d_grant}), 32'h2);
      chk("s4_rvalid2", 32'({i_rvalid, d_rvalid}), 32'h0);

      // rd and wr together: write wins
      cyc(); i_rd = 1; i_wr = 1; i_addr = 16'h0010; i_wdata = 16'hBEEF;
      smp();
      chk("s5_strobes", 32'({mem_rd, mem_wr}), 32'h1);
      chk("s5_addr", 32'(mem_addr), 32'h0010);
      chk("s5_wdata", 32'(mem_wdata), 32'hBEEF);
      cyc(); i_rd = 0; i_wr = 0; i_req = 0;
      smp();
      chk("s5_no_rv1", 32'(i_rvalid), 32'h0);
      cyc();
      smp();
      chk("s5_no_rv2", 32'(i_rvalid), 32'h0);
      chk("s5_idle", 32'({i_grant, d_grant}), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single four-banked main-memory port between the instruction-cache controller and the data-cache controller.
- Each cache controller issues whole-line bursts: up to four write-back words followed by four fill reads, with req held high for the whole burst.
- The arbiter grants one requester per burst, passes its commands through to memory, and returns read data to whichever requester issued each read.
- Sits between the two cache_controller instances and the memory system in the top-level processor.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data word width
RD_LAT, 2, cycles from an accepted mem_rd to mem_rdata valid (must be >= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req  in  1  I-side burst request; held high for the whole burst
i_rd  in  1  I-side read command
i_wr  in  1  I-side write command
i_addr  in  ADDR_W  I-side address
i_wdata  in  DATA_W  I-side write data
i_grant  out  1  I-side owns the memory port
i_stall  out  1  I-side command not accepted this cycle
i_rvalid  out  1  I-side read data valid
i_rdata  out  DATA_W  I-side read data
d_req, d_rd, d_wr, d_addr, d_wdata, d_grant, d_stall, d_rvalid, d_rdata  same as the I-side ports, for the D-side
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_stall  in  1  memory busy or bank conflict; the current command is not accepted
mem_rdata  in  DATA_W  memory read data

Behaviour:
- One clock domain. All state is held in dff flops and is cleared by the synchronous active-high rst.
- Reset values:
  - state = IDLE; grants = 0; mem_rd = mem_wr = 0; mem_addr = mem_wdata = 0.
  - rvalid = 0; read-tag pipe cleared.
  - last_owner = I, so D wins the first contention.
- States: IDLE, OWN_I, OWN_D, DRAIN.
- IDLE:
  - No memory strobes are driven.
  - Any requester with req=1 sees stall=1.
  - Only i_req -> OWN_I. Only d_req -> OWN_D.
  - Both -> the requester that is not last_owner (round-robin at burst boundaries).
  - The grant is registered: 1-cycle arbitration latency. A burst's first command can be accepted no earlier than the cycle after req rises.
- OWN_x:
  - x_grant = 1.
  - mem_rd/mem_wr/mem_addr/mem_wdata are driven combinationally from x's inputs.
  - x_stall = mem_stall.
  - The other side's stall = its req; its commands are never forwarded.
  - If x_rd and x_wr are both high, the write wins and mem_rd is forced to 0.
  - x_req=0 -> last_owner = x, then go to DRAIN if the tag pipe holds any valid entry, else IDLE. No strobes are driven in the release cycle.
- DRAIN:
  - No grants, no strobes.
  - Stay until the tag pipe is empty, then go to IDLE.
  - Requests arriving during DRAIN wait and are arbitrated in IDLE.
- Read-tag pipe:
  - RD_LAT-deep shift register of {valid, owner}.
  - Pushes {1, owner} when mem_rd=1 and mem_stall=0; otherwise pushes {0, -}.
  - At the pipe head: owner's rvalid = 1, and both rdata outputs carry mem_rdata.
  - The pipe shifts every cycle regardless of state, so returns continue through release and DRAIN.
- Writes carry no tag. A write is complete in the cycle it is accepted (mem_wr=1, mem_stall=0).
- A requester dropping req mid-burst is legal; it ends that burst.
- Both grants are never high together. A grant never changes while mem_stall holds a command pending.
- rst asserted mid-burst:
  - Next cycle everything is at its reset value.
  - In-flight read returns are discarded (no rvalid).

Test Plan:
- D-only burst: d_req for 4 writes then 4 reads to 0x1A00/02/04/06 -> d_grant 1 cycle after d_req; mem_wr on 4 consecutive cycles; d_rvalid 2 cycles after each read with mem_rdata values; i_* idle.
- Simultaneous i_req and d_req after reset -> D granted first; i_stall=1 throughout. Drop d_req -> DRAIN until the last read returns, then IDLE, then i_grant. Both raise req again -> I's burst is followed by D's (round-robin).
- mem_stall held 3 cycles mid-read-burst -> owner stall=1 for those cycles; the address is held; no tag pushed; rvalid count equals accepted reads (4).
- Owner drops req with 2 reads in flight; other side waiting -> both reads return to the old owner during DRAIN; the new grant appears only after the pipe is empty; the new owner's data is never mis-routed.
- rst pulsed during OWN_D with reads pending -> grants, strobes and rvalid are 0 the next cycle; a subsequent i_req is granted normally.
- Owner asserts rd and wr together at 0x0010 -> mem_wr=1, mem_rd=0, no tag pushed, no rvalid.
